// File: rtl/fetch_queue.sv
// Instruction fetch stage: drives a RAM read port, buffers returned words with their
// PCs, handles redirects and flushes on stores that hit prefetched addresses.
module fetch_queue #(
  parameter int             AW       = 12,
  parameter int             DW       = 16,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

  logic [AW-1:0] fpc_q, fpc_d;
  logic          inf_q, inf_d;
  logic [AW-1:0] inf_pc_q, inf_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] word_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];

  logic          pop, push, issue_ok, snoop_hit;
  logic [CW:0]   used;
  logic [AW-1:0] restart_pc;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? word_q[head_q] : '0;
  assign instr_pc    = instr_valid ? pc_q[head_q]   : '0;
  assign mem_addr    = fpc_q;

  // Credit: entries held plus the word in flight, minus the one leaving this cycle.
  assign used     = {1'b0, count_q} + {{CW{1'b0}}, inf_q} - {{CW{1'b0}}, pop};
  assign issue_ok = (used < DEPTH_L);

  always_comb begin
    snoop_hit = 1'b0;
    if (mem_wr_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < count_q) && !(k == 0 && pop) &&
            (pc_q[head_q + PW'(k)] == mem_wr_addr))
          snoop_hit = 1'b1;
      end
      if (inf_q && (inf_pc_q == mem_wr_addr))
        snoop_hit = 1'b1;
      if (issue_ok && (fpc_q == mem_wr_addr))
        snoop_hit = 1'b1;
    end
  end

  // Oldest PC not yet handed to the decoder; fetch resumes here after a snoop flush.
  always_comb begin
    if (instr_valid && !pop)
      restart_pc = pc_q[head_q];
    else if (pop && (count_q > CW'(1)))
      restart_pc = pc_q[head_q + PW'(1)];
    else if (inf_q)
      restart_pc = inf_pc_q;
    else
      restart_pc = fpc_q;
  end

  always_comb begin
    fpc_d    = fpc_q;
    inf_d    = 1'b0;
    inf_pc_d = inf_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    push     = 1'b0;
    if (redirect) begin
      fpc_d   = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (snoop_hit) begin
      fpc_d   = restart_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue_ok) begin
        inf_d    = 1'b1;
        inf_pc_d = fpc_q;
        fpc_d    = fpc_q + AW'(1);
      end
      push = inf_q;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q   <= RESET_PC;
      inf_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      fpc_q   <= fpc_d;
      inf_q   <= inf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    inf_pc_q <= inf_pc_d;
    if (push) begin
      word_q[tail_q] <= mem_data;
      pc_q[tail_q]   <= inf_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural RAM plus a program-order stream model that every
// delivered instruction is scored against, with directed scenarios and random traffic.
module tb_fetch_queue;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wr_en = 1'b0;
  logic [AW-1:0] mem_wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ram [1 << AW];
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] exp_next;

  fetch_queue #(.AW(AW), .DW(DW), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address seen at an edge appears after that edge.
  always @(posedge clk) begin
    mem_data <= ram[mem_addr];
    if (mem_wr_en) ram[mem_wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program-order model: after a restart at PC p, the decoder must see p, p+1, p+2, ...
  // Expected PCs are queued ahead; the word must match RAM as it stands when delivered.
  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + AW'(1);
    end
  endfunction

  function automatic void restart(input logic [AW-1:0] pc);
    exp_q.delete();
    exp_next = pc;
    refill();
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      restart('0);
    end else begin
      if (instr_valid && instr_ready) begin
        chk("stream_pc", 32'(instr_pc), 32'(exp_q[0]));
        chk("stream_word", 32'(instr), 32'(ram[instr_pc]));
        void'(exp_q.pop_front());
        refill();
      end
      if (redirect) restart(redirect_pc);
    end
  end

  task automatic next_pop(output logic [AW-1:0] pc, output logic [DW-1:0] w, output bit ok);
    ok = 1'b0;
    pc = '0;
    w  = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (instr_valid && instr_ready) begin
        pc = instr_pc;
        w  = instr;
        ok = 1'b1;
      end
      tick();
    end
    if (!ok) chk("pop_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    mem_wr_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [AW-1:0] p;
  logic [DW-1:0] w;
  bit            ok;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'($urandom);
    ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'h3333; ram[3] = 16'h4444;

    // Reset state and first-instruction latency.
    instr_ready = 1'b1;
    tick();
    tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'h0);
    rst = 1'b0;
    tick();
    chk("lat_valid_early", 32'(instr_valid), 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stream0_valid", 32'(instr_valid), 32'h1);
      chk("stream0_pc", 32'(instr_pc), 32'(i));
      chk("stream0_word", 32'(instr), 32'(ram[i]));
      tick();
    end

    // Stall: queue fills to DEPTH and issue stops.
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("stall_fpc", 32'(mem_addr), 32'h4);
    chk("stall_head_pc", 32'(instr_pc), 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", 32'(instr_valid), 32'h1);
      chk("drain_pc", 32'(instr_pc), 32'(i));
      tick();
    end

    // Redirect with a full queue.
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    redirect = 1'b1;
    redirect_pc = 12'h100;
    tick();
    redirect = 1'b0;
    chk("redir_mem_addr", 32'(mem_addr), 32'h100);
    chk("redir_valid_r1", 32'(instr_valid), 32'h0);
    tick();
    chk("redir_valid_r2", 32'(instr_valid), 32'h0);
    tick();
    chk("redir_valid_r3", 32'(instr_valid), 32'h1);
    chk("redir_pc_r3", 32'(instr_pc), 32'h100);

    // Snoop: store to the second entry while the head pops.
    redirect = 1'b1;
    redirect_pc = 12'h005;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("snoop_head", 32'(instr_pc), 32'h5);
    instr_ready = 1'b1;
    mem_wr_en = 1'b1;
    mem_wr_addr = 12'h006;
    wr_data = 16'hBEEF;
    tick();
    mem_wr_en = 1'b0;
    chk("snoop_refetch_addr", 32'(mem_addr), 32'h6);
    next_pop(p, w, ok);
    chk("snoop_pc", 32'(p), 32'h6);
    chk("snoop_word", 32'(w), 32'hBEEF);

    // Redirect and snoop in the same cycle; redirect target crosses the PC wrap.
    instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    redirect = 1'b1;
    redirect_pc = 12'hFFE;
    mem_wr_en = 1'b1;
    mem_wr_addr = instr_pc + 12'h1;
    wr_data = 16'h5A5A;
    tick();
    redirect = 1'b0;
    mem_wr_en = 1'b0;
    chk("both_mem_addr", 32'(mem_addr), 32'hFFE);
    instr_ready = 1'b1;
    next_pop(p, w, ok);
    chk("wrap_pc0", 32'(p), 32'hFFE);
    next_pop(p, w, ok);
    chk("wrap_pc1", 32'(p), 32'hFFF);
    next_pop(p, w, ok);
    chk("wrap_pc2", 32'(p), 32'h000);

    // Random traffic scored by the stream model.
    for (int c = 0; c < 4000; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        redirect = 1'b0;
      end else begin
        rst = 1'b0;
        redirect = ($urandom_range(0, 31) == 0);
        redirect_pc = AW'($urandom);
      end
      mem_wr_en = ($urandom_range(0, 4) == 0);
      mem_wr_addr = mem_addr - AW'($urandom_range(0, 6));
      wr_data = DW'($urandom);
      tick();
    end
    rst = 1'b0;
    redirect = 1'b0;
    mem_wr_en = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
